// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls the pipe until ack or timeout.
// Optional vector-result pass-through is enabled with the VALU_PASS_EN macro.
module mem_access #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] ReadData_o,
`ifdef VALU_PASS_EN
  input  logic [31:0] VALUResult_i,
  output logic [31:0] VALUResult_o,
`endif
  output logic        err_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           fail_q, fail_d;
  logic           err_q, err_d;
  logic           regwrite_q, regwrite_d;
  logic           memtoreg_q, memtoreg_d;
  logic [AW-1:0]  rdaddr_q, rdaddr_d;
  logic [DW-1:0]  alures_q, alures_d;
  logic [DW-1:0]  readdata_q, readdata_d;
`ifdef VALU_PASS_EN
  logic [DW-1:0]  valu_q, valu_d;
`endif
  logic           stall_c;
  logic           req_c;
  logic           mem_op_c;

  assign mem_op_c = MemRead_i | MemWrite_i;

  // Next-state, captured access and MEM/WB write-back
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    rdaddr_d   = rdaddr_q;
    alures_d   = alures_q;
    readdata_d = readdata_q;
`ifdef VALU_PASS_EN
    valu_d     = valu_q;
`endif
    stall_c    = 1'b0;
    req_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op_c) begin
          stall_c = 1'b1;
          addr_d  = ALUResult_i;
          wdata_d = RDData_i;
          we_d    = MemWrite_i;
          cnt_d   = '0;
          fail_d  = 1'b0;
          state_d = S_WAIT;
        end else begin
          regwrite_d = RegWrite_i;
          memtoreg_d = MemToReg_i;
          rdaddr_d   = RDaddr_i;
          alures_d   = ALUResult_i;
          readdata_d = '0;
`ifdef VALU_PASS_EN
          valu_d     = VALUResult_i;
`endif
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // An ack on the final allowed cycle still completes the access
        if (dmem_ack_i) begin
          rdata_d = we_q ? '0 : dmem_rdata_i;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          fail_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        regwrite_d = RegWrite_i & ~fail_q;
        memtoreg_d = MemToReg_i;
        rdaddr_d   = RDaddr_i;
        alures_d   = ALUResult_i;
        readdata_d = fail_q ? '0 : rdata_q;
`ifdef VALU_PASS_EN
        valu_d     = VALUResult_i;
`endif
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      fail_q     <= 1'b0;
      err_q      <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdaddr_q   <= '0;
      alures_q   <= '0;
      readdata_q <= '0;
`ifdef VALU_PASS_EN
      valu_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rdaddr_q   <= rdaddr_d;
      alures_q   <= alures_d;
      readdata_q <= readdata_d;
`ifdef VALU_PASS_EN
      valu_q     <= valu_d;
`endif
    end
  end

  // Stall must read low while reset is held, even if a memory op sits on the inputs
  assign stall_o      = stall_c & start_i;
  assign dmem_req_o   = req_c;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign RegWrite_o   = regwrite_q;
  assign MemToReg_o   = memtoreg_q;
  assign RDaddr_o     = rdaddr_q;
  assign ALUResult_o  = alures_q;
  assign ReadData_o   = readdata_q;
  assign err_o        = err_q;
`ifdef VALU_PASS_EN
  assign VALUResult_o = valu_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver pushes expected write-backs, a monitor pops them on each commit.
module tb_mem_access;

  localparam int TO = 4;
`ifdef VALU_PASS_EN
  localparam bit HAS_VALU = 1'b1;
`else
  localparam bit HAS_VALU = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        start_i;
  logic [31:0] ALUResult_i, RDData_i, dmem_rdata_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, dmem_ack_i;
  logic        stall_o, dmem_req_o, dmem_we_o, err_o, RegWrite_o, MemToReg_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, ALUResult_o, ReadData_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] valu_in;
  logic [31:0] valu_out;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] valu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          stalls;
    int          reqs;
    int          errs;
  } exp_t;

  exp_t q[$];

  always #5 clk_i = ~clk_i;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .start_i      (start_i),
    .ALUResult_i  (ALUResult_i),
    .RDData_i     (RDData_i),
    .RDaddr_i     (RDaddr_i),
    .RegWrite_i   (RegWrite_i),
    .MemToReg_i   (MemToReg_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .RegWrite_o   (RegWrite_o),
    .MemToReg_o   (MemToReg_o),
    .RDaddr_o     (RDaddr_o),
    .ALUResult_o  (ALUResult_o),
    .ReadData_o   (ReadData_o),
`ifdef VALU_PASS_EN
    .VALUResult_i (valu_in),
    .VALUResult_o (valu_out),
`endif
    .err_o        (err_o)
  );

`ifndef VALU_PASS_EN
  assign valu_out = 32'h0;
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] wb_act();
    return 128'({RegWrite_o, MemToReg_o, RDaddr_o, ALUResult_o, ReadData_o, valu_out});
  endfunction

  function automatic logic [127:0] wb_exp(input exp_t e);
    return 128'({e.rw, e.mtr, e.rd, e.alu, e.rdat, e.valu});
  endfunction

  // Monitor: a cycle with stall_o low commits at the next edge; check the write-back one cycle later
  initial begin : monitor
    exp_t e, last;
    bit pending, have_last;
    int sc, rc, ec;
    pending = 1'b0; have_last = 1'b0; sc = 0; rc = 0; ec = 0;
    forever begin
      @(negedge clk_i);
      if (pending) begin
        pending = 1'b0;
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wb_unexpected: got write-back %h with no expectation", wb_act());
        end else begin
          e = q.pop_front();
          chk("wb_data", wb_act(), wb_exp(e));
          chk("stall_cycles", 128'(sc), 128'(e.stalls));
          chk("req_cycles", 128'(rc), 128'(e.reqs));
          chk("err_pulses", 128'(ec), 128'(e.errs));
          last = e; have_last = 1'b1;
        end
        sc = 0; rc = 0; ec = 0;
      end else if (mon_en && have_last) begin
        chk("wb_hold", wb_act(), wb_exp(last));
      end
      if (!mon_en) begin
        sc = 0; rc = 0; ec = 0; have_last = 1'b0;
      end else begin
        if (dmem_req_o && q.size() > 0)
          chk("dmem_stable", 128'({dmem_addr_o, dmem_wdata_o, dmem_we_o}),
              128'({q[0].addr, q[0].wdata, q[0].we}));
        sc += int'(stall_o); rc += int'(dmem_req_o); ec += int'(err_o);
        if (!stall_o) pending = 1'b1;
      end
    end
  end

  // Driver + memory model: k = WAIT cycle carrying the ack, k > TO means the memory never answers
  task automatic run_instr(input logic rw, input logic mtr, input logic mr, input logic mw,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] vv, input int k, input logic [31:0] rdv);
    exp_t e;
    int j, cyc;
    bit mem, ok;
    j = 0; cyc = 0;
    RegWrite_i = rw; MemToReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    RDaddr_i = rd; ALUResult_i = alu; RDData_i = wd; valu_in = vv;
    mem = mr | mw;
    ok  = !mem || (k <= TO);
    e.rw     = ok ? rw : 1'b0;
    e.mtr    = mtr;
    e.rd     = rd;
    e.alu    = alu;
    e.rdat   = (mem && ok && mr && !mw) ? rdv : 32'h0;
    e.valu   = HAS_VALU ? vv : 32'h0;
    e.addr   = alu;
    e.wdata  = wd;
    e.we     = mw;
    e.stalls = !mem ? 0 : (ok ? k + 1 : TO + 1);
    e.reqs   = !mem ? 0 : (ok ? k : TO);
    e.errs   = ok ? 0 : 1;
    q.push_back(e);
    forever begin
      @(negedge clk_i);
      if (dmem_req_o) begin
        j++;
        dmem_ack_i   = (j == k);
        dmem_rdata_i = (j == k) ? rdv : $urandom();
      end else begin
        dmem_ack_i   = ($urandom_range(0, 3) == 0);
        dmem_rdata_i = $urandom();
      end
      if (!stall_o) break;
      cyc++;
      if (cyc > 4 * TO + 8) begin
        n_vec++; n_err++;
        $display("FAIL stall_bound: stall_o still high after %0d cycles", cyc);
        break;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic reset_in_wait();
    mon_en = 1'b0;
    RegWrite_i = 1'b1; MemToReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    RDaddr_i = 5'd12; ALUResult_i = 32'h300; RDData_i = 32'h0; valu_in = 32'h0;
    dmem_ack_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    chk("rst_pre_req", 128'(dmem_req_o), 128'(1));
    start_i = 1'b0;
    #1;
    chk("rst_ctl", 128'({stall_o, dmem_req_o, dmem_we_o, err_o}), 128'(0));
    chk("rst_dmem", 128'({dmem_addr_o, dmem_wdata_o}), 128'(0));
    chk("rst_wb", wb_act(), 128'(0));
    RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0;
    RDaddr_i = 5'd0; ALUResult_i = 32'h0;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBADC0DE5;
    @(negedge clk_i); dmem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack_wb", 128'({RegWrite_o, ReadData_o}), 128'(0));
    chk("late_ack_ctl", 128'({stall_o, dmem_req_o, err_o}), 128'(0));
    @(posedge clk_i); #1;
    mon_en = 1'b1;
  endtask

  initial begin : stim
    logic [1:0] cls;
    start_i = 1'b0;
    RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    RDaddr_i = 5'd0; ALUResult_i = 32'h0; RDData_i = 32'h0; valu_in = 32'h0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    #1;
    chk("por_ctl", 128'({stall_o, dmem_req_o, dmem_we_o, err_o}), 128'(0));
    chk("por_dmem", 128'({dmem_addr_o, dmem_wdata_o}), 128'(0));
    chk("por_wb", wb_act(), 128'(0));
    MemRead_i = 1'b0;
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1;
    mon_en = 1'b1;

    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0, 32'h0, 1, 32'h0);
    run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0, 32'hA5A5A5A5, 3, 32'hDEADBEEF);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h20, 32'h55, 32'h0, 1, 32'h0);
    run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h40, 32'h0, 32'h0, TO + 1, 32'h1234);
    run_instr(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h44, 32'h77, 32'h0, 2, 32'hFFFF0000);
    run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h48, 32'h0, 32'h5A5A5A5A, TO, 32'hCAFEF00D);
    run_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h99, 32'h0, 32'h11, 1, 32'h0);

    reset_in_wait();

    for (int n = 0; n < 200; n++) begin
      cls = 2'($urandom_range(0, 3));
      run_instr(1'($urandom()), 1'($urandom()), cls[0], cls[1], 5'($urandom()),
                $urandom(), $urandom(), $urandom(), int'($urandom_range(1, TO + 1)), $urandom());
    end

    repeat (3) @(negedge clk_i);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
